// File: rtl/image_frame_sequencer.sv
// ---------------------------------------------------------------------------
// image_frame_sequencer
//   Sequences one image frame through an external image_processor: latches
//   the per-frame configuration on start, streams IMG_WIDTH*IMG_HEIGHT source
//   pixels into the processor, collects the processor results into an output
//   stream and reports completion (done) or a drain timeout (err).
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   start, abort               frame start pulse / synchronous frame cancel
//   cfg_*                      per-frame config, latched on an accepted start
//   src_valid/src_pixel/src_ready   pixel source handshake
//   proc_*  (out)              registered pixel + config to image_processor
//   proc_pixel_out/proc_data_valid_out   results from image_processor
//   out_pixel/out_valid/out_last         result stream
//   in_col/in_row              position of the next pixel to accept
//   busy/done/err              frame status
// ---------------------------------------------------------------------------
module image_frame_sequencer #(
    parameter  int IMG_WIDTH     = 512,
    parameter  int IMG_HEIGHT    = 512,
    parameter  int DRAIN_TIMEOUT = 16,
    localparam int CW            = $clog2(IMG_WIDTH),
    localparam int RW            = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    cfg_operation_select,
    input  logic [7:0]    cfg_threshold_value,
    input  logic [7:0]    cfg_brightness_value,
    input  logic          src_valid,
    input  logic [23:0]   src_pixel,
    output logic          src_ready,
    output logic [23:0]   proc_pixel_in,
    output logic          proc_data_valid_in,
    output logic [1:0]    proc_operation_select,
    output logic [7:0]    proc_threshold_value,
    output logic [7:0]    proc_brightness_value,
    input  logic [23:0]   proc_pixel_out,
    input  logic          proc_data_valid_out,
    output logic [23:0]   out_pixel,
    output logic          out_valid,
    output logic          out_last,
    output logic [CW-1:0] in_col,
    output logic [RW-1:0] in_row,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int OCW  = $clog2(NPIX) + 1;
    localparam int TW   = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [OCW-1:0]  ocnt_q;
    logic [TW-1:0]   idle_q;
    logic            accept;
    logic            last_pos;

    // The cycle that presents out_last already commits the frame, so no
    // further source beat is taken in that cycle.
    assign src_ready = (state_q == STREAM) && !out_last;
    assign accept    = src_valid && src_ready;
    assign last_pos  = (col_q == CW'(IMG_WIDTH - 1)) && (row_q == RW'(IMG_HEIGHT - 1));
    assign busy      = (state_q == STREAM) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign in_col    = col_q;
    assign in_row    = row_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q               <= IDLE;
            col_q                 <= '0;
            row_q                 <= '0;
            ocnt_q                <= '0;
            idle_q                <= '0;
            err                   <= 1'b0;
            proc_pixel_in         <= 24'h000000;
            proc_data_valid_in    <= 1'b0;
            proc_operation_select <= 2'b00;
            proc_threshold_value  <= 8'd0;
            proc_brightness_value <= 8'd0;
            out_pixel             <= 24'h000000;
            out_valid             <= 1'b0;
            out_last              <= 1'b0;
        end else begin
            // Strobes default low; only an accept / a counted result raises them.
            proc_data_valid_in <= 1'b0;
            out_valid          <= 1'b0;
            out_last           <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        proc_operation_select <= cfg_operation_select;
                        proc_threshold_value  <= cfg_threshold_value;
                        proc_brightness_value <= cfg_brightness_value;
                        col_q   <= '0;
                        row_q   <= '0;
                        ocnt_q  <= '0;
                        idle_q  <= '0;
                        err     <= 1'b0;
                        state_q <= STREAM;
                    end
                end
                STREAM, DRAIN: begin
                    if (abort) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        ocnt_q  <= '0;
                        idle_q  <= '0;
                        state_q <= IDLE;
                    end else if (out_last) begin
                        // Completion may arrive while still in STREAM.
                        state_q <= DONE;
                    end else begin
                        if (accept) begin
                            proc_pixel_in      <= src_pixel;
                            proc_data_valid_in <= 1'b1;
                            if (last_pos) begin
                                col_q   <= '0;
                                row_q   <= '0;
                                state_q <= DRAIN;
                            end else if (col_q == CW'(IMG_WIDTH - 1)) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end
                        if (proc_data_valid_out) begin
                            out_valid <= 1'b1;
                            out_pixel <= proc_pixel_out;
                            out_last  <= (ocnt_q == OCW'(NPIX - 1));
                            ocnt_q    <= ocnt_q + 1'b1;
                            idle_q    <= '0;
                        end else if (state_q == DRAIN) begin
                            // Consecutive silent DRAIN cycles; the processor is
                            // presumed hung once the limit is reached.
                            if (idle_q == TW'(DRAIN_TIMEOUT - 1)) begin
                                err     <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                idle_q <= idle_q + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Bench for image_frame_sequencer with a 4x2 frame and a 1-cycle processor
// model (result = pixel ^ MASK, optionally limited to a number of results).
// Expected results are queued at frame start; a monitor pops on out_valid.
module tb_image_frame_sequencer;
    localparam int W = 4;
    localparam int H = 2;
    localparam int T = 4;
    localparam int N = W * H;
    localparam logic [23:0] MASK = 24'h5A3C96;

    logic clk, rst, start, abort;
    logic [1:0] cfg_op;
    logic [7:0] cfg_thr, cfg_bri;
    logic src_valid, src_ready;
    logic [23:0] src_pixel;
    logic [23:0] proc_pixel_in;
    logic proc_data_valid_in;
    logic [1:0] proc_operation_select;
    logic [7:0] proc_threshold_value, proc_brightness_value;
    logic [23:0] proc_pixel_out;
    logic proc_data_valid_out;
    logic [23:0] out_pixel;
    logic out_valid, out_last;
    logic [1:0] in_col;
    logic [0:0] in_row;
    logic busy, done, err;

    image_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DRAIN_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_operation_select(cfg_op), .cfg_threshold_value(cfg_thr),
        .cfg_brightness_value(cfg_bri),
        .src_valid(src_valid), .src_pixel(src_pixel), .src_ready(src_ready),
        .proc_pixel_in(proc_pixel_in), .proc_data_valid_in(proc_data_valid_in),
        .proc_operation_select(proc_operation_select),
        .proc_threshold_value(proc_threshold_value),
        .proc_brightness_value(proc_brightness_value),
        .proc_pixel_out(proc_pixel_out), .proc_data_valid_out(proc_data_valid_out),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_last(out_last),
        .in_col(in_col), .in_row(in_row), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor model: one cycle latency, stops after 'limit' results per frame.
    int limit = 1000;
    int emitted;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            proc_data_valid_out <= 1'b0;
            proc_pixel_out      <= '0;
            emitted             <= 0;
        end else begin
            proc_data_valid_out <= proc_data_valid_in && (emitted < limit);
            proc_pixel_out      <= proc_pixel_in ^ MASK;
            if (start) emitted <= 0;
            else if (proc_data_valid_in && emitted < limit) emitted <= emitted + 1;
        end
    end

    typedef struct { logic [23:0] px; logic last; } exp_t;
    exp_t q[$];
    int total = 0;
    int bad = 0;
    bit tmo_mode = 0;
    logic prev_acc = 0, last_prev = 0;
    logic [23:0] prev_pix = '0;
    logic [23:0] pix [N];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Record what the DUT should forward to the processor on this edge.
    always @(posedge clk) begin
        if (rst) begin
            prev_acc  = 1'b0;
            last_prev = 1'b0;
        end else begin
            prev_acc = src_valid && src_ready && !abort;
            prev_pix = src_pixel;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("pdv_in", {31'd0, proc_data_valid_in}, {31'd0, prev_acc});
            if (prev_acc) chk("pix_in", {8'd0, proc_pixel_in}, {8'd0, prev_pix});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_pixel", {8'd0, out_pixel}, {8'd0, e.px});
                    chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                end
            end else if (out_last) begin
                chk("last_wo_valid", 32'd1, 32'd0);
            end
            if (!tmo_mode) chk("done_after_last", {31'd0, done}, {31'd0, last_prev});
            last_prev = out_valid && out_last;
        end
    end

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_frame(input logic [1:0] op, input logic [7:0] thr,
                               input logic [7:0] bri, input int nexp);
        exp_t e;
        cfg_op = op; cfg_thr = thr; cfg_bri = bri; start = 1'b1;
        for (int k = 0; k < nexp; k++) begin
            e.px = pix[k] ^ MASK;
            e.last = (k == N - 1);
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        cfg_op = 2'($urandom); cfg_thr = 8'($urandom); cfg_bri = 8'($urandom);
        chk("cfg_op", {30'd0, proc_operation_select}, {30'd0, op});
        chk("cfg_thr", {24'd0, proc_threshold_value}, {24'd0, thr});
        chk("cfg_bri", {24'd0, proc_brightness_value}, {24'd0, bri});
        chk("busy_start", {31'd0, busy}, 32'd1);
        chk("err_start", {31'd0, err}, 32'd0);
    endtask

    task automatic drive(input int k0, input int k1, input bit gaps);
        for (int k = k0; k < k1; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    src_valid = 1'b0;
                    src_pixel = 24'($urandom);
                    @(negedge clk);
                end
            end
            chk("src_ready", {31'd0, src_ready}, 32'd1);
            chk("in_col", {30'd0, in_col}, k % W);
            chk("in_row", {31'd0, in_row}, k / W);
            src_valid = 1'b1;
            src_pixel = pix[k];
            @(negedge clk);
        end
        src_valid = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic finish_frame();
        int c;
        wait_done(c);
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("err_clean", {31'd0, err}, 32'd0);
        chk("queue_empty", q.size(), 32'd0);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_src_ready", {31'd0, src_ready}, 32'd0);
        chk("rst_pdv_in", {31'd0, proc_data_valid_in}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_col", {30'd0, in_col}, 32'd0);
        chk("rst_row", {31'd0, in_row}, 32'd0);
        chk("rst_pix_in", {8'd0, proc_pixel_in}, 32'd0);
        chk("rst_out_pix", {8'd0, out_pixel}, 32'd0);
        chk("rst_op", {30'd0, proc_operation_select}, 32'd0);
        chk("rst_thr", {24'd0, proc_threshold_value}, 32'd0);
        chk("rst_bri", {24'd0, proc_brightness_value}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int c;
        rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_pixel = '0;
        cfg_op = '0; cfg_thr = '0; cfg_bri = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals();
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Back-to-back frame, pixels 1..8.
        for (int k = 0; k < N; k++) pix[k] = 24'(k + 1);
        start_frame(2'b01, 8'd128, 8'd80, N);
        drive(0, N, 0);
        finish_frame();
        chk("cfg_hold_op", {30'd0, proc_operation_select}, 32'd1);
        chk("cfg_hold_thr", {24'd0, proc_threshold_value}, 32'd128);
        chk("cfg_hold_bri", {24'd0, proc_brightness_value}, 32'd80);

        // Random frames with source bubbles.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) pix[k] = 24'($urandom);
            start_frame(2'($urandom), 8'($urandom), 8'($urandom), N);
            drive(0, N, 1);
            finish_frame();
        end

        // Processor stalls after 5 results: drain timeout.
        limit = 5;
        for (int k = 0; k < N; k++) pix[k] = 24'($urandom);
        start_frame(2'b10, 8'd1, 8'd2, 5);
        drive(0, N, 0);
        tmo_mode = 1;
        wait_done(c);
        chk("tmo_cycles", c, T);
        chk("tmo_done", {31'd0, done}, 32'd1);
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_queue", q.size(), 32'd0);
        @(negedge clk);
        tmo_mode = 0;
        chk("tmo_idle_busy", {31'd0, busy}, 32'd0);
        chk("tmo_err_hold", {31'd0, err}, 32'd1);
        limit = 1000;

        // Abort after 3 accepts, with an accept offered in the abort cycle.
        for (int k = 0; k < N; k++) pix[k] = 24'($urandom);
        start_frame(2'b11, 8'd7, 8'd9, 3);
        drive(0, 3, 1);
        repeat (4) @(negedge clk);
        chk("abort_pre_q", q.size(), 32'd0);
        abort = 1'b1; src_valid = 1'b1; src_pixel = 24'($urandom);
        @(negedge clk);
        abort = 1'b0; src_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, src_ready}, 32'd0);
        chk("abort_col", {30'd0, in_col}, 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_noeffect", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) pix[k] = 24'($urandom);
        start_frame(2'b00, 8'd33, 8'd44, N);
        drive(0, N, 1);
        finish_frame();

        // Start ignored mid-frame, then reset mid-frame.
        for (int k = 0; k < N; k++) pix[k] = 24'($urandom);
        start_frame(2'b10, 8'd10, 8'd20, 3);
        drive(0, 3, 0);
        repeat (4) @(negedge clk);
        chk("rs_pre_q", q.size(), 32'd0);
        cfg_op = 2'b11; cfg_thr = 8'd200; cfg_bri = 8'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_op", {30'd0, proc_operation_select}, 32'd2);
        chk("ign_thr", {24'd0, proc_threshold_value}, 32'd10);
        chk("ign_bri", {24'd0, proc_brightness_value}, 32'd20);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        chk("ign_col", {30'd0, in_col}, 32'd3);
        src_valid = 1'b1; src_pixel = pix[3];
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        q.delete();
        src_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) pix[k] = 24'($urandom);
        start_frame(2'b01, 8'd5, 8'd6, N);
        drive(0, N, 1);
        finish_frame();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
